// File: rtl/mw_mem_arbiter_if.sv
// Request/response bundle between the pipeline requesters, the arbiter
// and the single-ported memory.
interface mw_mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              i_req;
  logic [AWIDTH-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DWIDTH-1:0] i_rdata;

  logic                  d_req;
  logic [AWIDTH-1:0]     d_addr;
  logic                  d_re;
  logic [DWIDTH/8-1:0]   d_wmask;
  logic [DWIDTH-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DWIDTH-1:0]     d_rdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [AWIDTH-1:0]     mem_addr;
  logic [DWIDTH/8-1:0]   mem_wmask;
  logic [DWIDTH-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DWIDTH-1:0]     mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_addr, d_re, d_wmask, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_valid, mem_addr, mem_wmask, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_addr, d_re, d_wmask, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_valid, mem_addr, mem_wmask, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mw_mem_arbiter.sv
// Fetch/data arbiter for one single-ported memory, one access in flight.
// DMEM_ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
module mw_mem_arbiter #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  mw_mem_arbiter_if.slave    bus,
  output logic               timeout_err
);
  localparam int MW = DWIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [MW-1:0]     wmask_q, wmask_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              own_d_q, own_d_d;
  logic              rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic d_win, i_win, d_bad, resp, tmo, done;

`ifdef DMEM_ARB_RR_EN
  logic prio_d_q, prio_d_d;
  assign d_win = bus.d_req && (!bus.i_req || prio_d_q);
`else
  assign d_win = bus.d_req;
`endif
  assign i_win = bus.i_req && !d_win;
  assign d_bad = !bus.d_re && (bus.d_wmask == '0);

  // A response beats a timeout landing in the same cycle
  assign resp = (state_q == WAIT_RESP) && bus.mem_rvalid;
  assign tmo  = (state_q == WAIT_RESP) && !bus.mem_rvalid
             && (cnt_q == CW'(TIMEOUT));
  assign done = resp || tmo;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wmask = wmask_q;
  assign bus.mem_wdata = wdata_q;
  assign timeout_err   = tmo;

  assign bus.d_rvalid = done && own_d_q;
  assign bus.i_rvalid = done && !own_d_q;
  assign bus.d_rdata  = (resp && own_d_q)  ? bus.mem_rdata : '0;
  assign bus.i_rdata  = (resp && !own_d_q) ? bus.mem_rdata : '0;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wmask_d       = wmask_q;
    wdata_d       = wdata_q;
    own_d_d       = own_d_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    bus.d_gnt     = 1'b0;
    bus.i_gnt     = 1'b0;
    bus.mem_valid = 1'b0;
`ifdef DMEM_ARB_RR_EN
    prio_d_d      = prio_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          d_win: begin
            bus.d_gnt = 1'b1;
            addr_d    = bus.d_addr;
            wmask_d   = bus.d_wmask;
            wdata_d   = bus.d_wdata;
            own_d_d   = 1'b1;
            rd_d      = (bus.d_wmask == '0);
            state_d   = d_bad ? IDLE : ISSUE;
`ifdef DMEM_ARB_RR_EN
            prio_d_d  = 1'b0;
`endif
          end
          i_win: begin
            bus.i_gnt = 1'b1;
            addr_d    = bus.i_addr;
            wmask_d   = '0;
            wdata_d   = '0;
            own_d_d   = 1'b0;
            rd_d      = 1'b1;
            state_d   = ISSUE;
`ifdef DMEM_ARB_RR_EN
            prio_d_d  = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      ISSUE: begin
        bus.mem_valid = 1'b1;
        cnt_d         = '0;
        if (bus.mem_ready) begin
          state_d = rd_q ? WAIT_RESP : IDLE;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      own_d_q <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      own_d_q <= own_d_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_d_q <= 1'b1;
    end else begin
      prio_d_q <= prio_d_d;
    end
  end
`endif
endmodule

// File: tb/tb_mw_mem_arbiter.sv
// Directed plus randomized transaction bench for mw_mem_arbiter with a
// transaction-level priority/latency model and a responding memory.
module tb_mw_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic timeout_err;

  mw_mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mw_mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  bit          pend_i, pend_d, prio_d;
  logic [31:0] ia, da, dwd;
  logic [3:0]  dmask;
  logic        dre;
  int          rdy_dly, rv_dly;
  logic [31:0] rsp;
  bit          tmo_mode;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_phase(input logic [31:0] ea, input logic [3:0] em,
                           input logic [31:0] ew, input bit is_rd,
                           input bit own_d);
    for (int k = 0; k <= rdy_dly; k++) begin
      bus.mem_ready = (k == rdy_dly);
      @(negedge clk);
      chk("mem_valid", bus.mem_valid, 1);
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_wmask", bus.mem_wmask, em);
      if (!is_rd) chk("mem_wdata", bus.mem_wdata, ew);
      chk("issue_gnt", {bus.i_gnt, bus.d_gnt}, 0);
      step();
    end
    bus.mem_ready = 1'b0;
    if (!is_rd) return;
    if (tmo_mode) begin
      int n = 0;
      bus.mem_rvalid = 1'b0;
      @(negedge clk);
      while (!timeout_err && n < 400) begin
        n++;
        step();
        @(negedge clk);
      end
      chk("tmo_wait_cycles", n, 255);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_d_rvalid", bus.d_rvalid, own_d);
      chk("tmo_i_rvalid", bus.i_rvalid, !own_d);
      chk("tmo_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hCAFE_F00D;
      @(negedge clk);
      chk("late_rvalid", {bus.i_rvalid, bus.d_rvalid, timeout_err}, 0);
      chk("late_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      step();
      bus.mem_rvalid = 1'b0;
      return;
    end
    for (int k = 0; k < rv_dly; k++) begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      @(negedge clk);
      chk("wait_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
      chk("wait_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      chk("wait_mem_valid", bus.mem_valid, 0);
      step();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rsp;
    @(negedge clk);
    chk("rsp_d_rvalid", bus.d_rvalid, own_d);
    chk("rsp_i_rvalid", bus.i_rvalid, !own_d);
    chk("rsp_d_rdata", bus.d_rdata, own_d ? rsp : 32'h0);
    chk("rsp_i_rdata", bus.i_rdata, own_d ? 32'h0 : rsp);
    chk("rsp_tmo", timeout_err, 0);
    step();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic round();
    for (int it = 0; it < 3 && (pend_i || pend_d); it++) begin
      bit wd;
      bus.i_req   = pend_i;
      bus.i_addr  = ia;
      bus.d_req   = pend_d;
      bus.d_addr  = da;
      bus.d_re    = dre;
      bus.d_wmask = dmask;
      bus.d_wdata = dwd;
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      wd = pend_d && (!pend_i || prio_d);
`else
      wd = pend_d;
`endif
      chk("i_gnt", bus.i_gnt, !wd);
      chk("d_gnt", bus.d_gnt, wd);
      chk("idle_mem_valid", bus.mem_valid, 0);
      chk("idle_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
      step();
      prio_d = !wd;
      if (wd) begin
        pend_d    = 1'b0;
        bus.d_req = 1'b0;
        if (!dre && dmask == 4'h0) continue;
        mem_phase(da, dmask, dwd, dmask == 4'h0, 1'b1);
      end else begin
        pend_i    = 1'b0;
        bus.i_req = 1'b0;
        mem_phase(ia, 4'h0, 32'h0, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic rand_d();
    logic [3:0] masks [3] = '{4'h1, 4'h3, 4'hF};
    int kind = $urandom_range(0, 3);
    da  = $urandom;
    dwd = $urandom;
    unique case (kind)
      0: begin dre = 1'b1; dmask = 4'h0; end
      1: begin dre = 1'b0; dmask = masks[$urandom_range(0, 2)]; end
      2: begin dre = 1'b1; dmask = masks[$urandom_range(0, 2)]; end
      default: begin dre = 1'b0; dmask = 4'h0; end
    endcase
  endtask

  initial begin
    reset_n = 1'b0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_addr = 0; bus.d_re = 0;
    bus.d_wmask = 0; bus.d_wdata = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    prio_d = 1'b1; tmo_mode = 1'b0;
    repeat (2) step();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_gnt", {bus.i_gnt, bus.d_gnt}, 0);
    chk("rst_rvalid", {bus.i_rvalid, bus.d_rvalid, timeout_err}, 0);
    reset_n = 1'b1;
    step();

    // fetch read, minimum latency
    pend_i = 1; ia = 32'h100; pend_d = 0;
    rdy_dly = 0; rv_dly = 0; rsp = 32'hDEAD_BEEF;
    round();

    // store with memory stalling
    pend_d = 1; da = 32'h200; dwd = 32'h1234_5678; dmask = 4'hF; dre = 0;
    rdy_dly = 3;
    round();

    // both requesting, repeated
    for (int r = 0; r < 4; r++) begin
      pend_i = 1; ia = 32'h400 + r * 4;
      pend_d = 1; rand_d();
      if (!dre && dmask == 4'h0) dre = 1'b1;
      rdy_dly = 0; rv_dly = 1; rsp = $urandom;
      round();
    end

    // malformed D alongside I
    pend_d = 1; da = 32'h500; dre = 0; dmask = 4'h0; dwd = 0;
    pend_i = 1; ia = 32'h600; rdy_dly = 0; rv_dly = 0; rsp = 32'h0BAD_CAFE;
    round();

    // load with no response
    pend_d = 1; pend_i = 0; da = 32'h700; dre = 1; dmask = 4'h0;
    rdy_dly = 0; tmo_mode = 1;
    round();
    tmo_mode = 0;

    // async reset while mem_valid is up
    bus.i_req = 1; bus.i_addr = 32'h800;
    @(negedge clk);
    chk("ar_gnt", bus.i_gnt, 1);
    step();
    bus.i_req = 0;
    @(negedge clk);
    chk("ar_issue_valid", bus.mem_valid, 1);
    #1 reset_n = 1'b0;
    #1 chk("ar_async_valid", bus.mem_valid, 0);
    step();
    reset_n = 1'b1;
    prio_d = 1'b1;
    step();

    // reset during WAIT_RESP drops the response
    bus.i_req = 1; bus.i_addr = 32'h900;
    @(negedge clk);
    chk("rw_gnt", bus.i_gnt, 1);
    step();
    bus.i_req = 0; bus.mem_ready = 1;
    @(negedge clk);
    chk("rw_valid", bus.mem_valid, 1);
    step();
    bus.mem_ready = 0;
    reset_n = 1'b0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_AAAA;
    #1 chk("rw_mem_valid", bus.mem_valid, 0);
    @(negedge clk);
    chk("rw_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    chk("rw_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    step();
    reset_n = 1'b1;
    bus.mem_rvalid = 0;
    prio_d = 1'b1;
    step();
    pend_i = 1; ia = 32'hA00; pend_d = 0;
    rdy_dly = 1; rv_dly = 2; rsp = 32'h600D_0001;
    round();

    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      pend_i = $urandom_range(0, 1);
      pend_d = $urandom_range(0, 1);
      if (!pend_i && !pend_d) pend_i = 1;
      ia = $urandom;
      rand_d();
      rdy_dly = $urandom_range(0, 3);
      rv_dly  = $urandom_range(0, 4);
      rsp     = $urandom;
      round();
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
